ndc_vertex_scheduler: RTL and testbench
=======================================

// Module: ndc_vertex_scheduler
// PURPOSE
//  Per-frame sequencer for the vertex->NDC transform pipeline.
//  On start: latches camera (C,u,v,n); walks num_tris triangles in vertex BRAM; streams 3 vertices/tri into the transform.
//  Regroups the 3 transformed vertices into one triangle and presents it on a valid/ready output toward the rasteriser.
//  The transform cannot stall, so issue is credit-gated against free output FIFO space.
// PARAMETERS
//  P_WIDTH      16  vertex coordinate width (signed)
//  C_WIDTH      18  camera position width (signed)
//  V_WIDTH      16  camera basis vector width (signed, Q.14)
//  NDC_W        25  transform output width per axis (signed)
//  TRI_W        12  triangle index width; max tris/frame = 2**TRI_W-1
//  BRAM_LAT     2   vertex BRAM read latency, cycles
//  XFORM_LAT    3   transform latency, xf_valid -> xf_valid_in, cycles
//  FIFO_DEPTH   4   output FIFO depth in triangles (power of 2)
// PORTS
//  clk          in   1              clock
//  rst          in   1              synchronous, active-high reset
//  start        in   1              1-cycle frame start pulse; ignored while busy
//  num_tris     in   TRI_W          triangle count, sampled on start
//  cam_pos      in   3*C_WIDTH      {Cx,Cy,Cz}, sampled on start
//  cam_u/v/n    in   3*V_WIDTH ea   camera basis, sampled on start
//  busy         out  1              high from accepted start until done
//  done         out  1              1-cycle pulse: last triangle accepted on output
//  vtx_addr     out  TRI_W+2        BRAM word address = 3*tri + k, k=0..2
//  vtx_rd       out  1              BRAM read enable
//  vtx_data     in   3*P_WIDTH      {Px,Py,Pz}, valid BRAM_LAT cycles after vtx_rd
//  xf_valid     out  1              vertex valid into transform
//  xf_P         out  3*P_WIDTH      vertex to transform
//  xf_C/u/v/n   out  as cam_*       latched camera, constant during frame
//  xf_valid_in  in   1              transform result valid
//  xf_ndc_x/y/z in   NDC_W ea       transform result
//  tri_valid    out  1              triangle output valid
//  tri_ready    in   1              downstream accept
//  tri_ndc      out  9*NDC_W        {v0xyz,v1xyz,v2xyz}
//  tri_id       out  TRI_W          triangle index
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; FIFO empty; credits = FIFO_DEPTH; camera regs 0.
//  FSM: IDLE -start-> (num_tris==0 ? DONE : ISSUE). ISSUE emits vtx_rd on 3 consecutive cycles (k=0,1,2).
//   After k=2: tri++; next tri==num_tris -> DRAIN; else credit>0 -> ISSUE; else WAIT_CREDIT.
//   WAIT_CREDIT: stay until credit>0, then ISSUE.
//   DRAIN: stay until all issued tris are accepted on output -> DONE.
//   DONE: done=1 for 1 cycle, busy=0 -> IDLE.
//  Credit: decremented entering ISSUE (k=0); incremented on tri_valid&&tri_ready; same-cycle inc+dec nets 0.
//   credit never <0 or >FIFO_DEPTH. FIFO therefore never overflows; no result is ever dropped.
//  xf_valid = vtx_rd delayed BRAM_LAT cycles (shift reg); xf_P = vtx_data that cycle. Vertex->result latency = BRAM_LAT+XFORM_LAT.
//  Collector: k-counter 0..2 on xf_valid_in; captures xyz into slot k. At k=2, pushes {3 slots, tri_id} into FIFO.
//   tri_id increments per push and resets to 0 on start.
//  Output: FIFO head on tri_ndc/tri_id; tri_valid = !empty. Payload holds while tri_valid&&!tri_ready.
//  Results arrive in issue order; no reordering logic required.
//  Flush: after rst deassert, xf_valid_in is ignored for BRAM_LAT+XFORM_LAT+1 cycles.
//   Rationale: the transform pipeline is not reset and drives valid high during its reset.
//  Reset mid-frame: immediate abort to IDLE; FIFO and collector cleared; no done pulse.
//  start while busy: ignored; no relatch of num_tris or camera.
//  tri_ready low indefinitely: issue stalls in WAIT_CREDIT after FIFO_DEPTH tris in flight; no loss.
//  Camera outputs change only on an accepted start.
// STRUCTURE
//  Package ndc_pkg: NDC_W/TRI_W defaults; vec3 typedefs; tri_ndc_t struct {ndc[3][3], id}; FSM state enum.
//  Sub-module ndc_tri_fifo: sync FIFO of tri_ndc_t, DEPTH param, push/pop/empty/full; first-word fall-through.
//  Credit counter, issue FSM, valid delay line and collector live in this module.
// TESTING
//  Behavioural transform model (XFORM_LAT delay, ndc=P-C) and BRAM model (BRAM_LAT) in bench.
//  1) num_tris=1, C=0, tri_ready=1 -> tri_valid once, tri_ndc = 3 BRAM vertices, tri_id=0.
//     done exactly 1 cycle after acceptance; busy low next cycle.
//  2) num_tris=0 -> no vtx_rd; done pulses within 2 cycles of start.
//  3) num_tris=10, tri_ready=0 for 200 cycles -> exactly FIFO_DEPTH=4 tris issued (12 vtx_rd), then stall.
//     Release tri_ready -> ids 0..9 in order; no drop.
//  4) num_tris=8, tri_ready random 50% -> scoreboard: all 8 tris match model; credit stays in [0,4].
//  5) rst asserted mid-frame (tri 3, k=1) -> outputs 0 next cycle; spurious xf_valid_in during flush ignored.
//     New start with num_tris=2 -> ids 0,1 only.
//  6) start pulsed again while busy with different num_tris/cam -> ignored; frame completes with original values.

Source files
------------

// File: rtl/ndc_pkg.sv
// Shared types for the vertex->NDC scheduler: default widths, vertex/triangle payloads, FSM states.
package ndc_pkg;

  localparam int unsigned PKG_NDC_W = 25;
  localparam int unsigned PKG_TRI_W = 12;

  typedef logic signed [PKG_NDC_W-1:0] ndc_t;

  typedef struct packed {
    ndc_t x;
    ndc_t y;
    ndc_t z;
  } ndc_vec3_t;

  typedef struct packed {
    ndc_vec3_t [2:0]        v;
    logic [PKG_TRI_W-1:0]   id;
  } tri_ndc_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitCredit,
    StDrain,
    StDone
  } sched_state_e;

endpackage

// File: rtl/ndc_tri_fifo.sv
// Synchronous first-word fall-through FIFO of assembled triangles.
module ndc_tri_fifo
  import ndc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  tri_ndc_t wdata,
  input  logic     pop,
  output tri_ndc_t rdata,
  output logic     empty,
  output logic     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  tri_ndc_t       mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ndc_vertex_scheduler.sv
// Per-frame issue sequencer: walks vertex BRAM, feeds the non-stallable transform under
// output-FIFO credit, and regroups transformed vertices into triangles for the rasteriser.
module ndc_vertex_scheduler
  import ndc_pkg::*;
#(
  parameter int unsigned P_WIDTH    = 16,
  parameter int unsigned C_WIDTH    = 18,
  parameter int unsigned V_WIDTH    = 16,
  parameter int unsigned NDC_W      = PKG_NDC_W,
  parameter int unsigned TRI_W      = PKG_TRI_W,
  parameter int unsigned BRAM_LAT   = 2,
  parameter int unsigned XFORM_LAT  = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [TRI_W-1:0]     num_tris,
  input  logic [3*C_WIDTH-1:0] cam_pos,
  input  logic [3*V_WIDTH-1:0] cam_u,
  input  logic [3*V_WIDTH-1:0] cam_v,
  input  logic [3*V_WIDTH-1:0] cam_n,
  output logic                 busy,
  output logic                 done,
  output logic [TRI_W+1:0]     vtx_addr,
  output logic                 vtx_rd,
  input  logic [3*P_WIDTH-1:0] vtx_data,
  output logic                 xf_valid,
  output logic [3*P_WIDTH-1:0] xf_P,
  output logic [3*C_WIDTH-1:0] xf_C,
  output logic [3*V_WIDTH-1:0] xf_u,
  output logic [3*V_WIDTH-1:0] xf_v,
  output logic [3*V_WIDTH-1:0] xf_n,
  input  logic                 xf_valid_in,
  input  logic [NDC_W-1:0]     xf_ndc_x,
  input  logic [NDC_W-1:0]     xf_ndc_y,
  input  logic [NDC_W-1:0]     xf_ndc_z,
  output logic                 tri_valid,
  input  logic                 tri_ready,
  output logic [9*NDC_W-1:0]   tri_ndc,
  output logic [TRI_W-1:0]     tri_id
);

  localparam int unsigned FLUSH_CYC = BRAM_LAT + XFORM_LAT + 1;
  localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FW        = $clog2(FLUSH_CYC + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

  sched_state_e         state_q, state_d;
  logic [TRI_W-1:0]     tri_cnt_q, tri_cnt_d;
  logic [TRI_W-1:0]     num_tris_q;
  logic [1:0]           k_q, k_d;
  logic [TRI_W+1:0]     addr_q, addr_d;
  logic [CW-1:0]        credit_q, credit_d;
  logic                 accept, issue_dec, pop;

  logic [3*C_WIDTH-1:0] cam_pos_q;
  logic [3*V_WIDTH-1:0] cam_u_q, cam_v_q, cam_n_q;

  logic [BRAM_LAT-1:0]  rd_pipe_q;
  logic [FW-1:0]        flush_q;

  logic [1:0]           coll_k_q;
  ndc_vec3_t [1:0]      slot_q;
  logic [TRI_W-1:0]     tri_id_q;
  logic                 res_valid, push;
  tri_ndc_t             push_data, head;
  logic                 fifo_empty, fifo_full;

  assign accept    = (state_q == StIdle) && start;
  assign vtx_rd    = (state_q == StIssue);
  assign vtx_addr  = vtx_rd ? addr_q : '0;
  assign issue_dec = vtx_rd && (k_q == 2'd0);
  assign pop       = tri_valid && tri_ready;
  assign credit_d  = credit_q + CW'(pop) - CW'(issue_dec);
  assign busy      = (state_q == StIssue) || (state_q == StWaitCredit) || (state_q == StDrain);
  assign done      = (state_q == StDone);

  always_comb begin
    state_d   = state_q;
    tri_cnt_d = tri_cnt_q;
    k_d       = k_q;
    addr_d    = addr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          tri_cnt_d = '0;
          k_d       = '0;
          addr_d    = '0;
          state_d   = (num_tris == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        addr_d = addr_q + 1'b1;
        if (k_q == 2'd2) begin
          k_d       = '0;
          tri_cnt_d = tri_cnt_q + 1'b1;
          if ((tri_cnt_q + 1'b1) == num_tris_q) state_d = StDrain;
          else if (credit_q != '0)             state_d = StIssue;
          else                                 state_d = StWaitCredit;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StWaitCredit: if (credit_q != '0) state_d = StIssue;
      // Looking at the next credit value lets done land one cycle after the last accept.
      StDrain:      if (credit_d == CREDIT_MAX) state_d = StDone;
      StDone:       state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tri_cnt_q  <= '0;
      k_q        <= '0;
      addr_q     <= '0;
      credit_q   <= CREDIT_MAX;
      num_tris_q <= '0;
      cam_pos_q  <= '0;
      cam_u_q    <= '0;
      cam_v_q    <= '0;
      cam_n_q    <= '0;
    end else begin
      state_q   <= state_d;
      tri_cnt_q <= tri_cnt_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      credit_q  <= credit_d;
      if (accept) begin
        num_tris_q <= num_tris;
        cam_pos_q  <= cam_pos;
        cam_u_q    <= cam_u;
        cam_v_q    <= cam_v;
        cam_n_q    <= cam_n;
      end
    end
  end

  assign xf_C = cam_pos_q;
  assign xf_u = cam_u_q;
  assign xf_v = cam_v_q;
  assign xf_n = cam_n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q[0] <= vtx_rd;
      for (int i = 1; i < BRAM_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign xf_valid = rd_pipe_q[BRAM_LAT-1];
  assign xf_P     = xf_valid ? vtx_data : '0;

  // The transform is not reset and asserts valid while in reset; mask it until it has drained.
  always_ff @(posedge clk) begin
    if (rst)                flush_q <= FW'(FLUSH_CYC);
    else if (flush_q != '0) flush_q <= flush_q - 1'b1;
  end

  assign res_valid = xf_valid_in && (flush_q == '0) && (state_q != StIdle);
  assign push      = res_valid && (coll_k_q == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_k_q <= '0;
      slot_q   <= '0;
      tri_id_q <= '0;
    end else if (accept) begin
      coll_k_q <= '0;
      tri_id_q <= '0;
    end else if (res_valid) begin
      if (coll_k_q == 2'd2) begin
        coll_k_q <= '0;
        tri_id_q <= tri_id_q + 1'b1;
      end else begin
        slot_q[coll_k_q[0]] <= '{x: xf_ndc_x, y: xf_ndc_y, z: xf_ndc_z};
        coll_k_q            <= coll_k_q + 1'b1;
      end
    end
  end

  always_comb begin
    push_data      = '0;
    push_data.v[0] = slot_q[0];
    push_data.v[1] = slot_q[1];
    push_data.v[2] = '{x: xf_ndc_x, y: xf_ndc_y, z: xf_ndc_z};
    push_data.id   = tri_id_q;
  end

  ndc_tri_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push && !fifo_full),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign tri_valid = !fifo_empty;
  assign tri_ndc   = tri_valid ? {head.v[0], head.v[1], head.v[2]} : '0;
  assign tri_id    = tri_valid ? head.id : '0;

endmodule

// File: tb/tb_ndc_vertex_scheduler.sv
// Bench for ndc_vertex_scheduler: BRAM and transform models, triangle scoreboard, frame table.
module tb_ndc_vertex_scheduler;

  localparam int BL = 2;
  localparam int XL = 3;

  logic          clk = 1'b0;
  logic          rst, start, tri_ready, spurious;
  logic [11:0]   num_tris;
  logic [53:0]   cam_pos;
  logic [47:0]   cam_u, cam_v, cam_n;
  logic          busy, done, vtx_rd, xf_valid, xf_valid_in, tri_valid;
  logic [13:0]   vtx_addr;
  logic [47:0]   vtx_data, xf_P, xf_u, xf_v, xf_n;
  logic [53:0]   xf_C;
  logic [24:0]   xf_ndc_x, xf_ndc_y, xf_ndc_z;
  logic [224:0]  tri_ndc;
  logic [11:0]   tri_id;

  always #5 clk = ~clk;

  ndc_vertex_scheduler #(
    .P_WIDTH(16), .C_WIDTH(18), .V_WIDTH(16), .NDC_W(25), .TRI_W(12),
    .BRAM_LAT(BL), .XFORM_LAT(XL), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_tris(num_tris), .cam_pos(cam_pos),
    .cam_u(cam_u), .cam_v(cam_v), .cam_n(cam_n), .busy(busy), .done(done),
    .vtx_addr(vtx_addr), .vtx_rd(vtx_rd), .vtx_data(vtx_data), .xf_valid(xf_valid),
    .xf_P(xf_P), .xf_C(xf_C), .xf_u(xf_u), .xf_v(xf_v), .xf_n(xf_n),
    .xf_valid_in(xf_valid_in), .xf_ndc_x(xf_ndc_x), .xf_ndc_y(xf_ndc_y),
    .xf_ndc_z(xf_ndc_z), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_ndc(tri_ndc), .tri_id(tri_id)
  );

  function automatic logic [24:0] sub(input logic [15:0] p, input logic [17:0] c);
    logic signed [24:0] a, b;
    a = {{9{p[15]}}, p};
    b = {{7{c[17]}}, c};
    return a - b;
  endfunction

  // Vertex BRAM with BL-cycle read latency.
  logic [47:0] bram [64];
  bit   [47:0] bp   [BL];
  always @(posedge clk) begin
    bp[0] <= vtx_rd ? bram[vtx_addr[5:0]] : 48'h0;
    for (int i = 1; i < BL; i++) bp[i] <= bp[i-1];
  end
  assign vtx_data = bp[BL-1];

  // Transform: ndc = P - C after XL cycles; not reset, can be forced valid.
  bit        xv [XL];
  bit [24:0] xx [XL];
  bit [24:0] xy [XL];
  bit [24:0] xz [XL];
  always @(posedge clk) begin
    xv[0] <= xf_valid;
    xx[0] <= sub(xf_P[47:32], xf_C[53:36]);
    xy[0] <= sub(xf_P[31:16], xf_C[35:18]);
    xz[0] <= sub(xf_P[15:0],  xf_C[17:0]);
    for (int i = 1; i < XL; i++) begin
      xv[i] <= xv[i-1];
      xx[i] <= xx[i-1];
      xy[i] <= xy[i-1];
      xz[i] <= xz[i-1];
    end
  end
  assign xf_valid_in = xv[XL-1] | spurious;
  assign xf_ndc_x    = xx[XL-1];
  assign xf_ndc_y    = xy[XL-1];
  assign xf_ndc_z    = xz[XL-1];

  typedef struct {
    logic [224:0] ndc;
    logic [11:0]  id;
  } exp_t;

  typedef struct {
    int          n;
    logic [17:0] cx, cy, cz;
    int          pct;
    int          exp_rd;
    int          exp_tris;
    bit          restart;
  } vec_t;

  exp_t         exp_q [$];
  logic [197:0] exp_cam;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, rd_count = 0, acc_count = 0, done_count = 0;
  int last_acc_cyc = -1, done_cyc = -1, start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Scoreboard and per-cycle properties.
  always @(negedge clk) begin
    if (!rst) begin
      int   inflight;
      exp_t e;
      if (vtx_rd) rd_count++;
      if (tri_valid && tri_ready) begin
        acc_count++;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_tri", {tri_id, tri_ndc}, '0);
        end else begin
          e = exp_q.pop_front();
          check("tri_ndc", tri_ndc, e.ndc);
          check("tri_id", tri_id, e.id);
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        check("busy_low_at_done", busy, 0);
      end
      if (busy) check("cam_latched", {xf_C, xf_u, xf_v, xf_n}, exp_cam);
      inflight = (rd_count + 2) / 3 - acc_count;
      check("credit_range", (inflight >= 0 && inflight <= 4), 1);
    end
  end

  task automatic prep_frame(input int n, input logic [17:0] cx, cy, cz);
    exp_t        e;
    logic [47:0] w;
    num_tris = 12'(n);
    cam_pos  = {cx, cy, cz};
    cam_u    = {16'($urandom), 32'($urandom)};
    cam_v    = {16'($urandom), 32'($urandom)};
    cam_n    = {16'($urandom), 32'($urandom)};
    exp_cam  = {cam_pos, cam_u, cam_v, cam_n};
    exp_q.delete();
    for (int t = 0; t < n; t++) begin
      e.ndc = '0;
      for (int k = 0; k < 3; k++) begin
        w     = bram[3*t+k];
        e.ndc = {e.ndc[149:0], sub(w[47:32], cx), sub(w[31:16], cy), sub(w[15:0], cz)};
      end
      e.id = 12'(t);
      exp_q.push_back(e);
    end
    rd_count = 0; acc_count = 0; done_count = 0;
    last_acc_cyc = -1; done_cyc = -1;
  endtask

  task automatic pulse_start();
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int exp_rd, input int exp_tris, input int pct,
                           input bit restart);
    for (int t = 0; t < 3000 && done_count == 0; t++) begin
      @(posedge clk); #1;
      tri_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
      start     = 1'b0;
      if (restart && t == 5) begin
        num_tris = 12'(n + 3);
        cam_pos  = ~cam_pos;
        cam_u    = ~cam_u;
        start    = 1'b1;
      end
    end
    start = 1'b0;
    check("done_seen", done_count > 0, 1);
    repeat (3) begin @(posedge clk); #1; end
    tri_ready = 1'b0;
    check("done_single_pulse", done_count, 1);
    check("vtx_rd_count", rd_count, exp_rd);
    check("tris_accepted", acc_count, exp_tris);
    check("scoreboard_empty", exp_q.size(), 0);
    if (n == 0) check("done_latency_empty", (done_cyc > start_cyc && done_cyc - start_cyc <= 2), 1);
    else        check("done_after_last_accept", done_cyc - last_acc_cyc, 1);
  endtask

  vec_t vecs [5];

  initial begin
    bit found;
    vecs[0] = '{1, 18'd0,          18'd0,          18'd0,    100, 3,  1, 1'b0};
    vecs[1] = '{0, 18'd5,          18'd5,          18'd5,    100, 0,  0, 1'b0};
    vecs[2] = '{5, 18'd100,        18'(-200),      18'd300,  100, 15, 5, 1'b1};
    vecs[3] = '{8, 18'(-7),        18'd12,         18'd1000, 50,  24, 8, 1'b0};
    vecs[4] = '{3, 18'h1ffff,      18'h20000,      18'd0,    30,  9,  3, 1'b1};

    for (int i = 0; i < 64; i++) bram[i] = {16'($urandom), 32'($urandom)};
    rst = 1'b1; start = 1'b0; tri_ready = 1'b0; spurious = 1'b0;
    num_tris = '0; cam_pos = '0; cam_u = '0; cam_v = '0; cam_n = '0; exp_cam = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, vtx_addr, vtx_rd, xf_valid, xf_P, xf_C, xf_u, xf_v,
                            xf_n, tri_valid, tri_id}, '0);
    check("reset_tri_ndc", tri_ndc, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end

    foreach (vecs[i]) begin
      prep_frame(vecs[i].n, vecs[i].cx, vecs[i].cy, vecs[i].cz);
      pulse_start();
      wait_done(vecs[i].n, vecs[i].exp_rd, vecs[i].exp_tris, vecs[i].pct, vecs[i].restart);
    end

    // Downstream stalled: issue must stop after four triangles in flight.
    prep_frame(10, 18'd40, 18'd50, 18'd60);
    tri_ready = 1'b0;
    pulse_start();
    repeat (200) begin @(posedge clk); #1; end
    check("stall_vtx_rd", rd_count, 12);
    check("stall_no_accept", acc_count, 0);
    check("stall_busy", busy, 1);
    wait_done(10, 30, 10, 100, 1'b0);

    // Reset in the middle of triangle 3, then a fresh two-triangle frame under flush noise.
    prep_frame(6, 18'd11, 18'd22, 18'd33);
    tri_ready = 1'b0;
    pulse_start();
    found = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (vtx_rd && vtx_addr == 14'd10) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_point_reached", found, 1);
    rst = 1'b1; spurious = 1'b1;
    @(posedge clk); #1;
    prep_frame(2, 18'($urandom), 18'($urandom), 18'($urandom));
    @(negedge clk);
    check("abort_outputs", {busy, done, vtx_addr, vtx_rd, xf_valid, xf_P, xf_C, xf_u, xf_v,
                            xf_n, tri_valid, tri_id}, '0);
    check("abort_tri_ndc", tri_ndc, '0);
    @(posedge clk); #1;
    rst = 1'b0; tri_ready = 1'b1;
    pulse_start();
    repeat (3) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    spurious = 1'b0;
    wait_done(2, 6, 2, 100, 1'b0);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(6, 1);
      prep_frame(n, 18'($urandom), 18'($urandom), 18'($urandom));
      pulse_start();
      wait_done(n, 3*n, n, $urandom_range(90, 20), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
